// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_gen_pkg;

    // Default width of the period/high/phase fields, in reference-clock cycles
    localparam int DEF_CNT_W  = 16;

    // Shortest period a channel can produce; smaller programmed values are raised to this
    localparam int MIN_PERIOD = 2;

    // Per-channel operating state
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PHASE_WAIT = 2'd1,
        RUN        = 2'd2,
        STOP       = 2'd3
    } ch_state_e;

endpackage

// File: rtl/clk_gen_ch.sv
// One generated-clock channel: shadowed period/high/phase, start delay and period counter.
// Latency: clk_out/tick are registered one cycle behind the counter, so the first high cycle follows the enabling edge by 1+PH.
// Backpressure: none; once started it free-runs, and en low lets the current period finish before idling.
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    input  logic [CNT_W-1:0] phase,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] eff_per;
    logic             wrap;

    // Degenerate periods (0 or 1) run as the minimum period so the counter always wraps
    assign eff_per = (per_q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : per_q;
    assign wrap    = (cnt_q == (eff_per - CNT_W'(1)));

    // State and datapath registers; reset clears every counter and shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ph_cnt_q <= '0;
            per_q    <= '0;
            hi_q     <= '0;
            ph_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_cnt_q <= ph_cnt_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            ph_q     <= ph_d;
        end
    end

    // Next state: sync or an IDLE exit restarts from fresh shadows; otherwise step the counters
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_cnt_d = ph_cnt_q;
        per_d    = per_q;
        hi_d     = hi_q;
        ph_d     = ph_q;
        if (sync || (state_q == IDLE)) begin
            cnt_d    = '0;
            ph_cnt_d = '0;
            if (en) begin
                per_d   = period;
                hi_d    = high;
                ph_d    = phase;
                state_d = (phase != '0) ? PHASE_WAIT : RUN;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                PHASE_WAIT: begin
                    if (!en) begin
                        state_d  = IDLE;
                        ph_cnt_d = '0;
                    end else if (ph_cnt_q == (ph_q - CNT_W'(1))) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                end
                // STOP only differs from RUN in that it idles at the wrap unless en returns
                RUN, STOP: begin
                    if (wrap) begin
                        cnt_d = '0;
                        if (en) begin
                            state_d = RUN;
                            per_d   = period;
                            hi_d    = high;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = en ? RUN : STOP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the current counter; sync forces a low cycle before the realigned period
    always_comb begin
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (!sync && ((state_q == RUN) || (state_q == STOP))) begin
            clk_out_d = (cnt_q < hi_q);
            tick_d    = (cnt_q == '0);
        end
    end

    // Output registers, cleared immediately by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign active  = (state_q != IDLE);

endmodule

// File: rtl/clk_gen_multi.sv
// Bank of NUM_CH independent generated clocks sharing one reference clock and a realign pulse.
// Latency: per channel, first high cycle and tick one cycle after the phase delay expires.
// Backpressure: none; channels are free-running and gated only by en.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH*CNT_W-1:0] high,
    input  logic [NUM_CH*CNT_W-1:0] phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .period  (period[g*CNT_W +: CNT_W]),
            .high    (high[g*CNT_W +: CNT_W]),
            .phase   (phase[g*CNT_W +: CNT_W]),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .active  (active[g])
        );
    end

endmodule
